pixel_repack: RTL and testbench

//   Parametrised byte-stream repacker: DAT_BYTES-wide memory words in, PIX_BYTES-wide pixels out.

---
 rtl/pixel_repack.sv | 122 ++++++++++++
 tb/tb_pixel_repack.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_repack.sv
// rtl/pixel_repack.sv - byte-stream repacker, DAT_BYTES-wide words in, PIX_BYTES-wide pixels out
//
// Purpose: buffers input bytes (little-endian, oldest byte at buffer index 0) and emits
//   PIX_BYTES-wide pixels with ready/valid on both sides, frame-end (last) handling and a
//   sticky flag for frames that end with a partial pixel.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   idat/ival/ilast input word, valid, last word of frame; irdy = word accepted this cycle
//   odat/oval/olast output pixel, valid, last complete pixel of frame; ordy = pixel taken
//   tail_err        sticky: a frame ended with leftover bytes that were dropped
//   err_clr         synchronous clear of tail_err (a same-cycle set wins)
module pixel_repack #(
  parameter int DAT_BYTES = 4,
  parameter int PIX_BYTES = 3,
  parameter int CAP_BYTES = 2 * ((DAT_BYTES > PIX_BYTES) ? DAT_BYTES : PIX_BYTES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*DAT_BYTES-1:0] idat,
  input  logic                   ival,
  input  logic                   ilast,
  output logic                   irdy,
  output logic [8*PIX_BYTES-1:0] odat,
  output logic                   oval,
  output logic                   olast,
  input  logic                   ordy,
  output logic                   tail_err,
  input  logic                   err_clr
);

  localparam int CNT_W = $clog2(CAP_BYTES + 1);
  localparam logic [CNT_W-1:0] DAT_C = CNT_W'(DAT_BYTES);
  localparam logic [CNT_W-1:0] PIX_C = CNT_W'(PIX_BYTES);

  // ST_DRAIN means the last word of a frame has been accepted and is being flushed.
  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       buf_q [CAP_BYTES];
  logic [7:0]       buf_d [CAP_BYTES];
  logic             tail_err_q, tail_err_d;
  logic             push, pop;
  logic [CNT_W-1:0] wr_base;

  // All outputs come from registered state only; irdy never looks at ordy.
  assign oval     = (count_q >= PIX_C);
  assign olast    = (state_q == ST_DRAIN) && oval && (int'(count_q) < 2 * PIX_BYTES);
  assign irdy     = rst && (state_q == ST_RUN) && (int'(count_q) <= CAP_BYTES - DAT_BYTES);
  assign tail_err = tail_err_q;

  always_comb begin
    odat = '0;
    for (int i = 0; i < PIX_BYTES; i++) begin
      odat[8*i +: 8] = buf_q[i];
    end
  end

  always_comb begin
    push       = ival && irdy;
    pop        = oval && ordy;
    state_d    = state_q;
    tail_err_d = err_clr ? 1'b0 : tail_err_q;
    count_d    = count_q + (push ? DAT_C : '0) - (pop ? PIX_C : '0);
    // New word lands just above the bytes that survive this cycle's pop.
    wr_base    = pop ? (count_q - PIX_C) : count_q;

    for (int i = 0; i < CAP_BYTES; i++) begin
      buf_d[i] = buf_q[i];
    end
    if (pop) begin
      for (int i = 0; i < CAP_BYTES - PIX_BYTES; i++) begin
        buf_d[i] = buf_q[i + PIX_BYTES];
      end
      for (int i = CAP_BYTES - PIX_BYTES; i < CAP_BYTES; i++) begin
        buf_d[i] = 8'h00;
      end
    end
    for (int i = 0; i < CAP_BYTES; i++) begin
      for (int j = 0; j < DAT_BYTES; j++) begin
        if (push && (int'(wr_base) + j == i)) begin
          buf_d[i] = idat[8*j +: 8];
        end
      end
    end

    if (push && ilast) begin
      state_d = ST_DRAIN;
    end

    // Frame flushed down to a partial pixel: drop it and reopen the input.
    if ((state_q == ST_DRAIN) && !oval) begin
      if (count_q != '0) begin
        tail_err_d = 1'b1;
      end
      count_d = '0;
      for (int i = 0; i < CAP_BYTES; i++) begin
        buf_d[i] = 8'h00;
      end
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      count_q    <= '0;
      tail_err_q <= 1'b0;
      for (int i = 0; i < CAP_BYTES; i++) begin
        buf_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tail_err_q <= tail_err_d;
      for (int i = 0; i < CAP_BYTES; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pixel_repack.sv
// tb/tb_pixel_repack.sv - self-checking bench for pixel_repack (D4/P3 and D8/P3 instances)
`timescale 1ns/1ps
module tb_pixel_repack;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] idat4;
  logic        ival4, ilast4, irdy4, oval4, olast4, ordy4, tail_err4, err_clr4;
  logic [23:0] odat4;
  logic [63:0] idat8;
  logic        ival8, ilast8, irdy8, oval8, olast8, ordy8, tail_err8, err_clr8;
  logic [23:0] odat8;

  pixel_repack #(.DAT_BYTES(4), .PIX_BYTES(3)) u_dut4 (
    .clk(clk), .rst(rst), .idat(idat4), .ival(ival4), .ilast(ilast4), .irdy(irdy4),
    .odat(odat4), .oval(oval4), .olast(olast4), .ordy(ordy4),
    .tail_err(tail_err4), .err_clr(err_clr4)
  );

  pixel_repack #(.DAT_BYTES(8), .PIX_BYTES(3)) u_dut8 (
    .clk(clk), .rst(rst), .idat(idat8), .ival(ival8), .ilast(ilast8), .irdy(irdy8),
    .odat(odat8), .oval(oval8), .olast(olast8), .ordy(ordy8),
    .tail_err(tail_err8), .err_clr(err_clr8)
  );

  typedef struct {
    logic [23:0] pix;
    logic        last;
  } pix_t;

  int         n_checks = 0;
  int         n_errors = 0;
  pix_t       exp4[$];
  pix_t       exp8[$];
  logic [7:0] pend4[$];
  logic [7:0] pend8[$];
  int         fpix4 = 0, fpix8 = 0, pops4 = 0, pops8 = 0;
  logic       exp_tail4 = 1'b0, exp_tail8 = 1'b0;
  logic       rnd4 = 1'b0, rnd8 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a frame is a byte list; every PIX_BYTES consecutive bytes form a pixel,
  // the final complete pixel carries last, any remainder is dropped and raises tail.
  task automatic model_word(input int nb, input logic [63:0] d, input logic l,
                            inout logic [7:0] pend[$], inout pix_t q[$],
                            inout int fpix, inout logic tail);
    pix_t e;
    for (int j = 0; j < nb; j++) pend.push_back(d[8*j +: 8]);
    while (pend.size() >= 3) begin
      e.pix  = {pend[2], pend[1], pend[0]};
      e.last = 1'b0;
      q.push_back(e);
      repeat (3) void'(pend.pop_front());
      fpix++;
    end
    if (l) begin
      if (fpix > 0 && q.size() > 0) begin
        e = q.pop_back();
        e.last = 1'b1;
        q.push_back(e);
      end
      if (pend.size() != 0) tail = 1'b1;
      pend.delete();
      fpix = 0;
    end
  endtask

  // Monitors sample at negedge: pops happen at the following posedge.
  initial begin
    logic       hold;
    logic [23:0] hd;
    logic       hl;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_oval4", oval4, 1);
          chk("hold_odat4", odat4, hd);
          chk("hold_olast4", olast4, hl);
        end
        if (!oval4) chk("olast_noval4", olast4, 0);
        if (oval4) begin
          chk("exp_avail4", exp4.size() != 0, 1);
          if (ordy4 && exp4.size() != 0) begin
            chk("odat4", odat4, exp4[0].pix);
            chk("olast4", olast4, exp4[0].last);
            void'(exp4.pop_front());
            pops4++;
          end
        end
        hold = oval4 && !ordy4;
        hd   = odat4;
        hl   = olast4;
        if (ival4 && irdy4) model_word(4, {32'h0, idat4}, ilast4, pend4, exp4, fpix4, exp_tail4);
      end
    end
  end

  initial begin
    logic       hold;
    logic [23:0] hd;
    logic       hl;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_oval8", oval8, 1);
          chk("hold_odat8", odat8, hd);
          chk("hold_olast8", olast8, hl);
        end
        if (!oval8) chk("olast_noval8", olast8, 0);
        if (oval8) begin
          chk("exp_avail8", exp8.size() != 0, 1);
          if (ordy8 && exp8.size() != 0) begin
            chk("odat8", odat8, exp8[0].pix);
            chk("olast8", olast8, exp8[0].last);
            void'(exp8.pop_front());
            pops8++;
          end
        end
        hold = oval8 && !ordy8;
        hd   = odat8;
        hl   = olast8;
        if (ival8 && irdy8) model_word(8, idat8, ilast8, pend8, exp8, fpix8, exp_tail8);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd4) ordy4 = ($urandom_range(0, 3) != 0);
      if (rnd8) ordy8 = ($urandom_range(0, 3) != 0);
    end
  end

  // Drivers are entered just after a posedge and return just after the accepting posedge.
  task automatic send4(input logic [31:0] d, input logic l);
    bit acc = 1'b0;
    idat4 = d; ilast4 = l; ival4 = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk); acc = irdy4;
      @(posedge clk); #1;
    end
    ival4 = 1'b0; ilast4 = 1'b0;
    chk("send4_acc", acc, 1);
  endtask

  task automatic send8(input logic [63:0] d, input logic l);
    bit acc = 1'b0;
    idat8 = d; ilast8 = l; ival8 = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk); acc = irdy8;
      @(posedge clk); #1;
    end
    ival8 = 1'b0; ilast8 = 1'b0;
    chk("send8_acc", acc, 1);
  endtask

  task automatic idle4();
    bit ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk); ok = (exp4.size() == 0) && irdy4;
    end
    chk("idle4", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle8();
    bit ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk); ok = (exp8.size() == 0) && irdy8;
    end
    chk("idle8", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic tail4_chk_clr();
    chk("tail_err4", tail_err4, exp_tail4);
    err_clr4 = 1'b1; @(posedge clk); #1; err_clr4 = 1'b0;
    exp_tail4 = 1'b0;
    chk("tail_clr4", tail_err4, 0);
  endtask

  task automatic tail8_chk_clr();
    chk("tail_err8", tail_err8, exp_tail8);
    err_clr8 = 1'b1; @(posedge clk); #1; err_clr8 = 1'b0;
    exp_tail8 = 1'b0;
    chk("tail_clr8", tail_err8, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int start;
    int words;
    int nw;
    rst = 1'b0;
    idat4 = '0; ival4 = 1'b0; ilast4 = 1'b0; ordy4 = 1'b0; err_clr4 = 1'b0;
    idat8 = '0; ival8 = 1'b0; ilast8 = 1'b0; ordy8 = 1'b0; err_clr8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oval", oval4, 0);
    chk("rst_irdy", irdy4, 0);
    chk("rst_olast", olast4, 0);
    chk("rst_tail", tail_err4, 0);
    chk("rst_odat", odat4, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("irdy_after_rst", irdy4, 1);

    // Basic packing with ordy=1; pixel follows the accepting cycle.
    ordy4 = 1'b1;
    send4(32'h03020100, 1'b0);
    chk("latency_oval", oval4, 1);
    chk("latency_odat", odat4, 24'h020100);
    send4(32'h07060504, 1'b0);
    send4(32'h0B0A0908, 1'b1);
    idle4();
    tail4_chk_clr();

    // Backpressure: buffer fills, output held, nothing lost after release.
    ordy4 = 1'b0;
    fork
      begin
        send4(32'h03020100, 1'b0);
        send4(32'h07060504, 1'b0);
        send4(32'h0B0A0908, 1'b1);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("bp_oval", oval4, 1);
        chk("bp_odat", odat4, 24'h020100);
        chk("bp_irdy", irdy4, 0);
        ordy4 = 1'b1;
      end
    join
    idle4();
    tail4_chk_clr();

    // 12-byte frame: four pixels, no tail.
    send4(32'h4B4A4948, 1'b0);
    send4(32'h4F4E4D4C, 1'b0);
    send4(32'h53525150, 1'b1);
    idle4();
    chk("tail_none12", tail_err4, 0);

    // 8-byte frame: two pixels, two bytes dropped, input closed while draining.
    send4(32'h13121110, 1'b0);
    send4(32'h17161514, 1'b1);
    chk("irdy_drain", irdy4, 0);
    idle4();
    chk("tail_set8b", tail_err4, 1);
    chk("tail_model8b", tail_err4, exp_tail4);

    // Asynchronous reset mid-stream with five bytes buffered.
    ordy4 = 1'b0;
    send4(32'h23222120, 1'b0);
    send4(32'h27262524, 1'b0);
    ordy4 = 1'b1;
    @(posedge clk); #1;
    ordy4 = 1'b0;
    chk("pre_rst_oval", oval4, 1);
    chk("pre_rst_odat", odat4, 24'h252423);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_oval", oval4, 0);
    chk("mid_rst_irdy", irdy4, 0);
    chk("mid_rst_olast", olast4, 0);
    chk("mid_rst_tail", tail_err4, 0);
    exp4.delete(); pend4.delete(); fpix4 = 0; exp_tail4 = 1'b0;
    exp8.delete(); pend8.delete(); fpix8 = 0; exp_tail8 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    ordy4 = 1'b1;
    send4(32'h33323130, 1'b1);
    chk("rst_first_pix", odat4, 24'h323130);
    chk("rst_first_last", olast4, 1);
    idle4();
    tail4_chk_clr();

    // D8/P3: 24-byte frame, eight pixels, no tail.
    ordy8 = 1'b1;
    start = pops8;
    send8(64'h0706050403020100, 1'b0);
    send8(64'h0F0E0D0C0B0A0908, 1'b0);
    send8(64'h1716151413121110, 1'b1);
    idle8();
    chk("pix8_count", pops8 - start, 8);
    chk("tail8_none", tail_err8, 0);

    // Random frames on D8 with random gaps and backpressure.
    rnd8 = 1'b1;
    words = 0;
    while (words < 1500) begin
      nw = $urandom_range(1, 4);
      for (int w = 0; w < nw; w++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send8({$urandom, $urandom}, w == nw - 1);
      end
      words += nw;
      idle8();
      tail8_chk_clr();
    end
    rnd8 = 1'b0;
    ordy8 = 1'b1;

    // Random frames on D4.
    rnd4 = 1'b1;
    words = 0;
    while (words < 3000) begin
      nw = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send4($urandom, w == nw - 1);
      end
      words += nw;
      idle4();
      tail4_chk_clr();
    end
    rnd4 = 1'b0;
    ordy4 = 1'b1;
    chk("pend4_empty", pend4.size(), 0);
    chk("pend8_empty", pend8.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
